debug_slave_sysclk_bridge: RTL and testbench

- Parametrised system-clock side of the Nios II JTAG debug slave.
- Receives the virtual-JTAG IR value, the DR shift-register snapshot, and toggle-encoded update-IR/exit1-DR events from the tck domain, and resynchronises the events into clk.
- Captures the DR into jdo and decodes IR into per-channel take_action/take_no_action strobes.
- Generalises the fixed 38-bit, 2-bit-IR design with configurable widths, optional per-channel ack-held actions, overrun detection and a capture counter.

---
 rtl/debug_slave_sysclk_bridge_if.sv | 38 +++
 rtl/debug_slave_sysclk_bridge.sv | 132 +++++++++++++
 tb/tb_debug_slave_sysclk_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_slave_sysclk_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_slave_sysclk_bridge_if
// Purpose  : Bus bundle between the tck-side debug logic and the sysclk bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface debug_slave_sysclk_bridge_if #(
    parameter int DR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int COUNT_WIDTH = 8
);
    localparam int NUM_CH = 2**IR_WIDTH;

    logic [IR_WIDTH-1:0]    ir_in;
    logic [DR_WIDTH-1:0]    sr;
    logic                   vs_uir_toggle;
    logic                   vs_e1dr_toggle;
    logic [NUM_CH-1:0]      action_ack;
    logic                   clear_overrun;
    logic [DR_WIDTH-1:0]    jdo;
    logic [IR_WIDTH-1:0]    ir_q;
    logic [NUM_CH-1:0]      take_action;
    logic [NUM_CH-1:0]      take_no_action;
    logic                   busy;
    logic                   overrun;
    logic [COUNT_WIDTH-1:0] capture_count;

    modport master (
        output ir_in, sr, vs_uir_toggle, vs_e1dr_toggle, action_ack, clear_overrun,
        input  jdo, ir_q, take_action, take_no_action, busy, overrun, capture_count
    );

    modport slave (
        input  ir_in, sr, vs_uir_toggle, vs_e1dr_toggle, action_ack, clear_overrun,
        output jdo, ir_q, take_action, take_no_action, busy, overrun, capture_count
    );
endinterface
`default_nettype wire

// File: rtl/debug_slave_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : debug_slave_sysclk_bridge
// Purpose  : Resynchronises JTAG debug events into clk, captures DR, decodes IR.
// Revision : 1.0 - initial release
// ============================================================================
module debug_slave_sysclk_bridge #(
    parameter int                         DR_WIDTH    = 38,
    parameter int                         IR_WIDTH    = 2,
    parameter int                         ACTION_BIT  = 35,
    parameter int                         SYNC_STAGES = 2,
    parameter logic [(2**IR_WIDTH)-1:0]   HOLD_MASK   = '0,
    parameter int                         COUNT_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    debug_slave_sysclk_bridge_if.slave bus
);
    localparam int NUM_CH = 2**IR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_e1dr_sync;
    logic                   r_uir_prev;
    logic                   r_e1dr_prev;
    logic [DR_WIDTH-1:0]    r_jdo;
    logic [IR_WIDTH-1:0]    r_ir_q;
    logic [IR_WIDTH-1:0]    r_ch_q;
    logic                   r_act_q;
    logic                   r_overrun;
    logic [COUNT_WIDTH-1:0] r_capture_count;

    logic                   w_uir_stb;
    logic                   w_e1dr_stb;
    logic                   w_capture;
    logic                   w_overrun_set;
    logic [IR_WIDTH-1:0]    w_ir_eff;
    logic [NUM_CH-1:0]      w_ch_onehot;
    logic [NUM_CH-1:0]      w_take_action;
    logic [NUM_CH-1:0]      w_take_no_action;

    assign w_uir_stb  = r_uir_sync[SYNC_STAGES-1] ^ r_uir_prev;
    assign w_e1dr_stb = r_e1dr_sync[SYNC_STAGES-1] ^ r_e1dr_prev;
    // A capture coinciding with update-IR must see the IR just shifted in
    assign w_ir_eff   = w_uir_stb ? bus.ir_in : r_ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_uir_sync      <= '0;
            r_e1dr_sync     <= '0;
            r_uir_prev      <= 1'b0;
            r_e1dr_prev     <= 1'b0;
            r_jdo           <= '0;
            r_ir_q          <= '0;
            r_ch_q          <= '0;
            r_act_q         <= 1'b0;
            r_overrun       <= 1'b0;
            r_capture_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir_toggle};
            r_e1dr_sync <= {r_e1dr_sync[SYNC_STAGES-2:0], bus.vs_e1dr_toggle};
            r_uir_prev  <= r_uir_sync[SYNC_STAGES-1];
            r_e1dr_prev <= r_e1dr_sync[SYNC_STAGES-1];
            if (w_uir_stb) begin
                r_ir_q <= bus.ir_in;
            end
            if (w_capture) begin
                r_jdo           <= bus.sr;
                r_ch_q          <= w_ir_eff;
                r_act_q         <= bus.sr[ACTION_BIT];
                r_capture_count <= r_capture_count + COUNT_WIDTH'(1);
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_capture        = 1'b0;
        w_overrun_set    = 1'b0;
        w_ch_onehot      = '0;
        w_take_action    = '0;
        w_take_no_action = '0;
        w_ch_onehot[r_ch_q] = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_e1dr_stb) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_overrun_set = w_e1dr_stb;
                w_next_state  = HOLD_MASK[r_ch_q] ? ST_WAIT_ACK : ST_IDLE;
            end
            ST_WAIT_ACK: begin
                w_overrun_set = w_e1dr_stb;
                if (bus.action_ack[r_ch_q]) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Strobes decode registered state only, so jdo is already stable
        if (r_state != ST_IDLE) begin
            w_take_action    = r_act_q ? w_ch_onehot : '0;
            w_take_no_action = r_act_q ? '0 : w_ch_onehot;
        end
    end

    assign bus.jdo            = r_jdo;
    assign bus.ir_q           = r_ir_q;
    assign bus.take_action    = w_take_action;
    assign bus.take_no_action = w_take_no_action;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.overrun        = r_overrun;
    assign bus.capture_count  = r_capture_count;
endmodule
`default_nettype wire

// File: tb/tb_debug_slave_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_slave_sysclk_bridge
// Purpose  : Self-checking bench: vector table, corner sequences, random + model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_slave_sysclk_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        tu, te;
    logic [3:0]  ack;
    logic        clr;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int ecount   = 0;

    always #5 clk = ~clk;

    debug_slave_sysclk_bridge_if #(.DR_WIDTH(38), .IR_WIDTH(2), .COUNT_WIDTH(8)) aif ();
    debug_slave_sysclk_bridge_if #(.DR_WIDTH(38), .IR_WIDTH(2), .COUNT_WIDTH(8)) bif ();

    assign aif.ir_in = ir_in;  assign bif.ir_in = ir_in;
    assign aif.sr = sr;        assign bif.sr = sr;
    assign aif.vs_uir_toggle = tu;   assign bif.vs_uir_toggle = tu;
    assign aif.vs_e1dr_toggle = te;  assign bif.vs_e1dr_toggle = te;
    assign aif.action_ack = ack;     assign bif.action_ack = ack;
    assign aif.clear_overrun = clr;  assign bif.clear_overrun = clr;

    debug_slave_sysclk_bridge #(
        .DR_WIDTH(38), .IR_WIDTH(2), .ACTION_BIT(35), .SYNC_STAGES(2),
        .HOLD_MASK(4'b0100), .COUNT_WIDTH(8)
    ) u_dut_a (.clk(clk), .reset(reset), .bus(aif.slave));

    debug_slave_sysclk_bridge #(
        .DR_WIDTH(38), .IR_WIDTH(2), .ACTION_BIT(35), .SYNC_STAGES(3),
        .HOLD_MASK(4'b0000), .COUNT_WIDTH(8)
    ) u_dut_b (.clk(clk), .reset(reset), .bus(bif.slave));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model (one slot per DUT) ----------
    int          m_stages [2] = '{2, 3};
    logic [3:0]  m_hold   [2] = '{4'b0100, 4'b0000};
    logic        hu [2][6];          // toggle samples, [0] = this edge
    logic        he [2][6];
    int          ph    [2];          // 0 idle, 1 first strobe cycle, 2 awaiting ack
    logic [37:0] m_jdo [2];
    logic [1:0]  m_ch  [2];
    logic [1:0]  m_irq [2];
    logic        m_act [2];
    logic        m_ovr [2];
    logic [7:0]  m_cnt [2];

    task automatic model_step(input int d);
        logic su, se;
        if (reset) begin
            for (int i = 0; i < 6; i++) begin hu[d][i] = 1'b0; he[d][i] = 1'b0; end
            ph[d] = 0; m_jdo[d] = '0; m_ch[d] = '0; m_irq[d] = '0;
            m_act[d] = 1'b0; m_ovr[d] = 1'b0; m_cnt[d] = '0;
        end else begin
            for (int i = 5; i > 0; i--) begin hu[d][i] = hu[d][i-1]; he[d][i] = he[d][i-1]; end
            hu[d][0] = tu;
            he[d][0] = te;
            // an event is seen once its toggle sample is m_stages edges old
            su = hu[d][m_stages[d]] ^ hu[d][m_stages[d]+1];
            se = he[d][m_stages[d]] ^ he[d][m_stages[d]+1];
            if (ph[d] == 0) begin
                if (clr) m_ovr[d] = 1'b0;
                if (se) begin
                    m_jdo[d] = sr;
                    m_ch[d]  = su ? ir_in : m_irq[d];
                    m_act[d] = sr[35];
                    m_cnt[d] = m_cnt[d] + 8'd1;
                    ph[d]    = 1;
                end
            end else begin
                if (se) m_ovr[d] = 1'b1;
                else if (clr) m_ovr[d] = 1'b0;
                if (ph[d] == 1) ph[d] = m_hold[d][m_ch[d]] ? 2 : 0;
                else if (ack[m_ch[d]]) ph[d] = 0;
            end
            if (su) m_irq[d] = ir_in;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic sb_cmp(input int d, input logic [37:0] jdo, input logic [1:0] irq,
                          input logic [3:0] ta, input logic [3:0] tna, input logic bsy,
                          input logic ovr, input logic [7:0] cnt);
        logic [3:0] oh;
        oh = 4'b0001 << m_ch[d];
        chk($sformatf("sb%0d_jdo", d), 64'(jdo), 64'(m_jdo[d]));
        chk($sformatf("sb%0d_ir_q", d), 64'(irq), 64'(m_irq[d]));
        chk($sformatf("sb%0d_take_action", d), 64'(ta), 64'((ph[d] != 0 && m_act[d]) ? oh : 4'b0));
        chk($sformatf("sb%0d_take_no_action", d), 64'(tna), 64'((ph[d] != 0 && !m_act[d]) ? oh : 4'b0));
        chk($sformatf("sb%0d_busy", d), 64'(bsy), 64'(ph[d] != 0));
        chk($sformatf("sb%0d_overrun", d), 64'(ovr), 64'(m_ovr[d]));
        chk($sformatf("sb%0d_count", d), 64'(cnt), 64'(m_cnt[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            sb_cmp(0, aif.jdo, aif.ir_q, aif.take_action, aif.take_no_action,
                   aif.busy, aif.overrun, aif.capture_count);
            sb_cmp(1, bif.jdo, bif.ir_q, bif.take_action, bif.take_no_action,
                   bif.busy, bif.overrun, bif.capture_count);
        end
    end

    // ---------------- directed helpers -------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one capture to DUT A and records its strobe over a bounded window
    task automatic capture(input logic [1:0] ir, input logic [37:0] d, input bit same_edge,
                           output logic [3:0] ta, output logic [3:0] tna, output int width);
        ir_in = ir;
        if (!same_edge) begin
            tu = ~tu;
            tick(5);
        end else begin
            tu = ~tu;
        end
        sr = d;
        te = ~te;
        ta = '0; tna = '0; width = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if ((aif.take_action | aif.take_no_action) != 4'b0) begin
                width++;
                ta  = ta | aif.take_action;
                tna = tna | aif.take_no_action;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] d;
        logic [3:0]  exp_ta;
        logic [3:0]  exp_tna;
    } vec_t;

    initial begin
        vec_t tbl [4];
        logic [3:0] ta, tna;
        int w, lat_a, lat_b, cnt_a, busy_a, seen;

        tbl[0] = '{2'd1, 38'h08_0000_0ABC, 4'b0010, 4'b0000};
        tbl[1] = '{2'd0, 38'h00_0000_1234, 4'b0000, 4'b0001};
        tbl[2] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
        tbl[3] = '{2'd1, 38'h37_FFFF_FFFF, 4'b0000, 4'b0010};

        reset = 1'b1; tu = 1'b0; te = 1'b0; ir_in = '0; sr = '0; ack = '0; clr = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_jdo", 64'(aif.jdo), 64'h0);
        chk("reset_strobes", 64'({aif.take_action, aif.take_no_action}), 64'h0);
        chk("reset_flags", 64'({aif.busy, aif.overrun, aif.ir_q}), 64'h0);
        chk("reset_count", 64'(aif.capture_count), 64'h0);

        // update-IR and capture latency, both synchroniser depths
        tick(1);
        ir_in = 2'd1; tu = ~tu;
        lat_a = 0; lat_b = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (aif.ir_q == 2'd1 && lat_a == 0) lat_a = k;
            if (bif.ir_q == 2'd1 && lat_b == 0) lat_b = k;
        end
        chk("uir_latency_a", 64'(lat_a), 64'd3);
        chk("uir_latency_b", 64'(lat_b), 64'd4);
        tick(1);
        sr = 38'h08_0000_0ABC; te = ~te; ecount++;
        lat_a = 0; lat_b = 0; cnt_a = 0; busy_a = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (aif.busy && lat_a == 0) lat_a = k;
            if (bif.busy && lat_b == 0) lat_b = k;
            if (aif.take_action == 4'b0010) cnt_a++;
            if (aif.busy) busy_a++;
        end
        chk("e1dr_latency_a", 64'(lat_a), 64'd3);
        chk("e1dr_latency_b", 64'(lat_b), 64'd4);
        chk("first_strobe_width", 64'(cnt_a), 64'd1);
        chk("first_busy_width", 64'(busy_a), 64'd1);
        chk("first_jdo", 64'(aif.jdo), 64'h08_0000_0ABC);
        chk("first_count", 64'(aif.capture_count), 64'd1);

        for (int i = 0; i < 4; i++) begin
            tick(1);
            capture(tbl[i].ir, tbl[i].d, 1'b0, ta, tna, w);
            ecount++;
            chk($sformatf("vec%0d_ta", i), 64'(ta), 64'(tbl[i].exp_ta));
            chk($sformatf("vec%0d_tna", i), 64'(tna), 64'(tbl[i].exp_tna));
            chk($sformatf("vec%0d_width", i), 64'(w), 64'd1);
            chk($sformatf("vec%0d_jdo", i), 64'(aif.jdo), 64'(tbl[i].d));
            chk($sformatf("vec%0d_ir_q", i), 64'(aif.ir_q), 64'(tbl[i].ir));
            chk($sformatf("vec%0d_count", i), 64'(aif.capture_count), 64'(ecount));
        end

        // held channel 2: wrong acks, overruns, clear races, then correct ack
        tick(1);
        ir_in = 2'd2; tu = ~tu; tick(5);
        ack = 4'b0011; sr = 38'h08_0000_0001; te = ~te; ecount++;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (aif.take_action != 4'b0) seen = 1;
        end
        chk("hold_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_wrong_ack", 64'(aif.take_action), 64'b0100);
        end
        tick(1);
        sr = 38'h15_5555_5555; te = ~te; tick(5);
        @(negedge clk);
        chk("ovr_set", 64'(aif.overrun), 64'd1);
        chk("ovr_jdo_kept", 64'(aif.jdo), 64'h08_0000_0001);
        chk("ovr_count_kept", 64'(aif.capture_count), 64'(ecount));
        chk("ovr_still_held", 64'(aif.take_action), 64'b0100);
        tick(1);
        te = ~te; tick(2); clr = 1'b1; tick(1); clr = 1'b0;
        @(negedge clk);
        chk("ovr_set_beats_clear", 64'(aif.overrun), 64'd1);
        tick(3);
        clr = 1'b1; tick(1); clr = 1'b0;
        @(negedge clk);
        chk("ovr_lone_clear", 64'(aif.overrun), 64'd0);
        chk("held_before_ack", 64'(aif.take_action), 64'b0100);
        tick(1);
        ack = 4'b0100; tick(1); ack = 4'b0000;
        @(negedge clk);
        chk("held_dropped", 64'(aif.take_action), 64'b0);
        chk("held_busy_dropped", 64'(aif.busy), 64'd0);

        // simultaneous update-IR and exit1-DR must use the new IR
        tick(2);
        capture(2'd3, 38'h00_0000_0055, 1'b1, ta, tna, w);
        ecount++;
        chk("same_edge_tna", 64'(tna), 64'b1000);
        chk("same_edge_ta", 64'(ta), 64'b0000);
        chk("same_edge_width", 64'(w), 64'd1);

        // counter wrap from a fresh reset
        tick(1);
        reset = 1'b1; tu = 1'b0; te = 1'b0; tick(1); reset = 1'b0;
        ecount = 0;
        ir_in = 2'd0; tu = ~tu; tick(5);
        for (int i = 0; i < 256; i++) begin
            sr = 38'(i); te = ~te; tick(7);
            if (i == 254) begin
                @(negedge clk);
                chk("count_255", 64'(aif.capture_count), 64'd255);
                tick(1);
            end
        end
        @(negedge clk);
        chk("count_wrap", 64'(aif.capture_count), 64'd0);

        // reset while a held strobe is pending
        tick(1);
        ir_in = 2'd2; tu = ~tu; tick(5);
        te = ~te;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (aif.busy) seen = 1;
        end
        chk("rst_wait_busy", 64'(seen), 64'd1);
        tick(2);
        reset = 1'b1; tu = 1'b0; te = 1'b0; tick(1); reset = 1'b0;
        @(negedge clk);
        chk("rst_abort_outputs", 64'({aif.take_action, aif.take_no_action, aif.busy,
            aif.overrun, aif.ir_q, aif.capture_count}), 64'h0);
        chk("rst_abort_jdo", 64'(aif.jdo), 64'h0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((aif.take_action | aif.take_no_action) != 4'b0 || aif.busy) seen = 1;
        end
        chk("rst_no_strobe", 64'(seen), 64'd0);

        // randomized traffic, checked by the model every cycle
        tick(1);
        for (int i = 0; i < 600; i++) begin
            ir_in = 2'($urandom_range(0, 3));
            sr    = 38'({$urandom(), $urandom()});
            ack   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0;
            clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) tu = ~tu;
            if ($urandom_range(0, 5) == 0) te = ~te;
            tick(1);
        end
        ack = '0; clr = 1'b0;
        tick(10);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
